alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue pipeline stage that sits directly upstream of the ALU in the RISC-V core. It takes a fetched RV32I instruction plus register-file read data, and produces the ALU's two operands and 4-bit operation code, the destination register, and the branch and memory flags. Decoded results are held in a registered output stage with a one-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: upstream holds valid instruction and operands.
- `in_ready` out 1: stage can accept.
- `instr` in 32: RV32I instruction word.
- `pc` in 32: address of `instr`.
- `rs1_data`, `rs2_data` in 32 each: register-file read values.
- `out_valid` out 1: output bundle valid.
- `out_ready` in 1: downstream (EX) accepts.
- `alu_in1`, `alu_in2` out 32 each: ALU operands.
- `alu_op` out 4: ALU operation code.
- `rd` out 5: destination register.
- `reg_write` out 1: writeback enable.
- `is_branch` out 1: conditional branch.
- `branch_on_zero` out 1: branch taken when ALU Zero equals this bit.
- `is_load`, `is_store` out 1 each: memory access; the ALU computes the address.
- `illegal` out 1: unsupported or malformed encoding.

## Operation
- ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, U_HIGH_EQ=0111, S_HIGH_EQ=1000, U_LOWER=1001, S_LOWER=1010, SLL=1101, SRL=1110, SRA=1111.
- OP (0110011): `in1`=rs1, `in2`=rs2.
  - funct3/funct7 map to ADD/SUB, SLL, SLT→S_LOWER, SLTU→U_LOWER, XOR, SRL/SRA, OR, AND.
  - funct7 other than 0000000 (or 0100000 for SUB/SRA) sets illegal.
- OP-IMM (0010011): `in2` = sign-extended imm[11:0]. Same mapping; there is no SUBI.
  - SLLI/SRLI/SRAI: imm[11:5] must be 0000000, or 0100000 for SRAI; otherwise illegal.
- Shifts (register and immediate): `in2` = {27'b0, amount[4:0]}. Upper bits are always masked.
- LUI: `in1`=0, `in2`={imm[31:12],12'b0}, ADD.
- AUIPC: `in1`=pc, same `in2`, ADD.
- LOAD: ADD rs1 + I-imm; `is_load`=1; `reg_write`=1.
- STORE: ADD rs1 + S-imm; `is_store`=1; `reg_write`=0.
- BRANCH: `in1`=rs1, `in2`=rs2, `is_branch`=1, `reg_write`=0.
  - BEQ: SUB, `branch_on_zero`=1.
  - BNE: SUB, `branch_on_zero`=0.
  - BLT: S_LOWER, `branch_on_zero`=0.
  - BGE: S_HIGH_EQ, `branch_on_zero`=0.
  - BLTU: U_LOWER, `branch_on_zero`=0.
  - BGEU: U_HIGH_EQ, `branch_on_zero`=0.
  - funct3 010/011 is illegal.
- Any other opcode (including JAL/JALR), or instr[1:0]≠11: `illegal`=1, `reg_write`=0, `alu_op`=ADD, operands 0.
- `rd`=instr[11:7] for OP, OP-IMM, LUI, AUIPC, LOAD; otherwise 0. `rd`=0 forces `reg_write`=0.
- Buffering: main output register plus one skid entry.
  - `in_ready` = !skid_valid.
  - Accept when `in_valid && in_ready`.
  - If the main register is empty or being drained, the decoded word loads main; otherwise it loads skid.
  - When main drains and skid is full, skid moves to main.

## Timing
- Reset values: `out_valid`=0, skid_valid=0, `in_ready`=1 after the first reset edge, every data output 0.
- Latency: accept at edge N → `out_valid`=1 with data after edge N.
  - Sustained throughput is 1 per cycle while `out_ready`=1.
- Output data is stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake or flush.
- `in_ready` falls only after a cycle where `out_valid && !out_ready` and a new word was accepted (skid full).
  - It rises the cycle after `out_ready` drains main.
- `flush` (any state): main and skid are cleared at the edge; `out_valid`=0 and `in_ready`=1 next cycle. Input offered in the flush cycle is dropped.
- `rst` and `flush` together behave as `rst`. Reset mid-stall discards both entries.
- Simultaneous drain and accept with skid empty: the new word goes directly to main with no bubble.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle: out_valid=1, in1=5, in2=7, alu_op=0000, rd=3, reg_write=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → alu_op=1111, in2=0x00000004, illegal=0. SLL with rs2=0xFFFFFF23 → in2=0x00000003.
- BGEU x1,x2 → alu_op=0111, is_branch=1, branch_on_zero=0, reg_write=0. BEQ → alu_op=0001, branch_on_zero=1.
- Back-to-back words A, B, C with out_ready=0 from the cycle A appears:
  - A is held; B goes to skid; in_ready=0; C is not accepted.
  - out_ready=1 → A, B, C emitted in order with no loss or duplication.
- Flush while main and skid are full → next cycle out_valid=0, in_ready=1. The following word then emerges with 1-cycle latency.
- JAL (0x0000006F), funct3=010 branch, and instr[1:0]=00 → illegal=1, reg_write=0. LUI x0 → reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the ALU: combinational decode into a
// registered output word backed by a one-entry skid buffer.
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_op,
   output logic [4:0]  rd,
   output logic        reg_write,
   output logic        is_branch,
   output logic        branch_on_zero,
   output logic        is_load,
   output logic        is_store,
   output logic        illegal
);

   localparam logic [3:0] OP_ADD       = 4'b0000;
   localparam logic [3:0] OP_SUB       = 4'b0001;
   localparam logic [3:0] OP_AND       = 4'b0010;
   localparam logic [3:0] OP_OR        = 4'b0011;
   localparam logic [3:0] OP_XOR       = 4'b0100;
   localparam logic [3:0] OP_U_HIGH_EQ = 4'b0111;
   localparam logic [3:0] OP_S_HIGH_EQ = 4'b1000;
   localparam logic [3:0] OP_U_LOWER   = 4'b1001;
   localparam logic [3:0] OP_S_LOWER   = 4'b1010;
   localparam logic [3:0] OP_SLL       = 4'b1101;
   localparam logic [3:0] OP_SRL       = 4'b1110;
   localparam logic [3:0] OP_SRA       = 4'b1111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        reg_write;
      logic        is_branch;
      logic        boz;
      logic        is_load;
      logic        is_store;
      logic        illegal;
   } dec_t;

   dec_t        dec;
   dec_t        main_q, main_d, skid_q, skid_d;
   logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic        ill, f7_zero, f7_alt_ok, accept, main_free;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_u, shamt_r, shamt_i;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[31:25];
   assign f7_zero   = (funct7 == F7_ZERO);
   assign f7_alt_ok = f7_zero || (funct7 == F7_ALT);
   assign imm_i     = {{20{instr[31]}}, instr[31:20]};
   assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u     = {instr[31:12], 12'b0};
   assign shamt_r   = {27'b0, rs2_data[4:0]};
   assign shamt_i   = {27'b0, instr[24:20]};

   always_comb begin
      dec = '0;
      ill = 1'b0;
      if (instr[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (opcode)
            OPC_OP: begin
               dec.in1       = rs1_data;
               dec.in2       = rs2_data;
               dec.rd        = instr[11:7];
               dec.reg_write = 1'b1;
               ill           = !f7_zero;
               case (funct3)
                  3'b000: begin
                     dec.op = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                     ill    = !f7_alt_ok;
                  end
                  3'b001: begin
                     dec.op  = OP_SLL;
                     dec.in2 = shamt_r;
                  end
                  3'b010: dec.op = OP_S_LOWER;
                  3'b011: dec.op = OP_U_LOWER;
                  3'b100: dec.op = OP_XOR;
                  3'b101: begin
                     dec.op  = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                     dec.in2 = shamt_r;
                     ill     = !f7_alt_ok;
                  end
                  3'b110: dec.op = OP_OR;
                  default: dec.op = OP_AND;
               endcase
            end
            OPC_OP_IMM: begin
               dec.in1       = rs1_data;
               dec.in2       = imm_i;
               dec.rd        = instr[11:7];
               dec.reg_write = 1'b1;
               case (funct3)
                  3'b000: dec.op = OP_ADD;
                  3'b001: begin
                     dec.op  = OP_SLL;
                     dec.in2 = shamt_i;
                     ill     = !f7_zero;
                  end
                  3'b010: dec.op = OP_S_LOWER;
                  3'b011: dec.op = OP_U_LOWER;
                  3'b100: dec.op = OP_XOR;
                  3'b101: begin
                     dec.op  = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                     dec.in2 = shamt_i;
                     ill     = !f7_alt_ok;
                  end
                  3'b110: dec.op = OP_OR;
                  default: dec.op = OP_AND;
               endcase
            end
            OPC_LUI, OPC_AUIPC: begin
               dec.in1       = (opcode == OPC_AUIPC) ? pc : 32'b0;
               dec.in2       = imm_u;
               dec.rd        = instr[11:7];
               dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
               dec.in1       = rs1_data;
               dec.in2       = imm_i;
               dec.rd        = instr[11:7];
               dec.reg_write = 1'b1;
               dec.is_load   = 1'b1;
            end
            OPC_STORE: begin
               dec.in1      = rs1_data;
               dec.in2      = imm_s;
               dec.is_store = 1'b1;
            end
            OPC_BRANCH: begin
               dec.in1       = rs1_data;
               dec.in2       = rs2_data;
               dec.is_branch = 1'b1;
               case (funct3)
                  3'b000: begin
                     dec.op  = OP_SUB;
                     dec.boz = 1'b1;
                  end
                  3'b001: dec.op = OP_SUB;
                  3'b100: dec.op = OP_S_LOWER;
                  3'b101: dec.op = OP_S_HIGH_EQ;
                  3'b110: dec.op = OP_U_LOWER;
                  3'b111: dec.op = OP_U_HIGH_EQ;
                  default: ill = 1'b1;
               endcase
            end
            default: ill = 1'b1;
         endcase
      end
      // A malformed word issues as a harmless ADD 0,0 that never writes back.
      if (ill) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

   assign accept    = in_valid && !skid_vld_q;
   assign main_free = !main_vld_q || out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (main_free) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = dec;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign in_ready       = !skid_vld_q;
   assign out_valid      = main_vld_q;
   assign alu_in1        = main_q.in1;
   assign alu_in2        = main_q.in2;
   assign alu_op         = main_q.op;
   assign rd             = main_q.rd;
   assign reg_write      = main_q.reg_write;
   assign is_branch      = main_q.is_branch;
   assign branch_on_zero = main_q.boz;
   assign is_load        = main_q.is_load;
   assign is_store       = main_q.is_store;
   assign illegal        = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-derived expected words go into a
// scoreboard queue on acceptance and are compared when the stage presents them.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data, alu_in1, alu_in2;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic        reg_write, is_branch, branch_on_zero, is_load, is_store, illegal;

   typedef struct {
      logic [78:0] v;
      logic [78:0] m;
   } sb_t;

   localparam logic [78:0] ALL  = {79{1'b1}};
   localparam logic [78:0] MILL = 79'h21;

   sb_t         q[$];
   sb_t         cur;
   logic        acc;
   logic [78:0] obs;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_op(alu_op), .rd(rd), .reg_write(reg_write), .is_branch(is_branch),
      .branch_on_zero(branch_on_zero), .is_load(is_load), .is_store(is_store),
      .illegal(illegal)
   );

   assign obs = {alu_in1, alu_in2, alu_op, rd, reg_write, is_branch,
                 branch_on_zero, is_load, is_store, illegal};

   function automatic logic [78:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op, input logic [4:0] r,
                                      input logic rw, input logic br, input logic bz,
                                      input logic ld, input logic st, input logic il);
      return {a, b, op, r, rw, br, bz, ld, st, il};
   endfunction

   task automatic chk(input string tag, input logic [78:0] o, input logic [78:0] e,
                      input logic [78:0] m);
      checks++;
      assert ((o & m) === (e & m)) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
      end
   endtask

   // One clock: score the output side and record acceptance at the falling edge.
   task automatic tick();
      @(negedge clk);
      acc = 1'b0;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", 79'(out_valid), 79'(0), ALL);
            end else begin
               chk("out_word", obs, q[0].v, q[0].m);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && in_ready) begin
            q.push_back(cur);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [78:0] e, input logic [78:0] m);
      logic got;
      instr    = ins;
      pc       = p;
      rs1_data = a;
      rs2_data = b;
      cur.v    = e;
      cur.m    = m;
      in_valid = 1'b1;
      got      = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = acc;
      end
      in_valid = 1'b0;
      if (!got) chk("accept_timeout", 79'(got), 79'(1), ALL);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
      cur.v = '0; cur.m = ALL; acc = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 79'(out_valid), 79'(0), ALL);
      chk("rst_in_ready", 79'(in_ready), 79'(1), ALL);
      chk("rst_data", obs, 79'(0), ALL);

      // Streaming with out_ready high: one word per cycle, no bubbles.
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'h0, 5'd3, 1, 0, 0, 0, 0, 0), ALL);
      chk("latency", 79'(out_valid), 79'(1), ALL);
      send(32'h40435293, 32'h0, 32'h80000000, 32'h0,
           mk(32'h80000000, 32'h4, 4'hF, 5'd5, 1, 0, 0, 0, 0, 0), ALL);
      chk("no_bubble", 79'(out_valid), 79'(1), ALL);
      send(32'h002093B3, 32'h0, 32'h12345678, 32'hFFFFFF23,
           mk(32'h12345678, 32'h3, 4'hD, 5'd7, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h0020F463, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'h7, 5'd0, 0, 1, 0, 0, 0, 0), ALL);
      send(32'h00208463, 32'h0, 32'd4, 32'd4, mk(32'd4, 32'd4, 4'h1, 5'd0, 0, 1, 1, 0, 0, 0), ALL);
      send(32'hFFF08213, 32'h0, 32'd9, 32'h0, mk(32'd9, 32'hFFFFFFFF, 4'h0, 5'd4, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h12345037, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h12345000, 4'h0, 5'd0, 0, 0, 0, 0, 0, 0), ALL);
      send(32'hABCDE337, 32'h0, 32'h77, 32'h0, mk(32'h0, 32'hABCDE000, 4'h0, 5'd6, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h00001097, 32'h100, 32'h0, 32'h0, mk(32'h100, 32'h1000, 4'h0, 5'd1, 1, 0, 0, 0, 0, 0), ALL);
      send(32'hFFC12283, 32'h0, 32'h1000, 32'h0,
           mk(32'h1000, 32'hFFFFFFFC, 4'h0, 5'd5, 1, 0, 0, 1, 0, 0), ALL);
      send(32'h00312423, 32'h0, 32'h2000, 32'h55, mk(32'h2000, 32'h8, 4'h0, 5'd0, 0, 0, 0, 0, 1, 0), ALL);
      send(32'h0000006F, 32'h40, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0, 0, 1), ALL);
      send(32'h002081B0, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0, 0, 1), ALL);
      send(32'h0020A463, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0, 0, 1), MILL);
      send(32'h022081B3, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0, 0, 1), MILL);
      send(32'h40109093, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0, 0, 1), MILL);
      tick();
      tick();
      chk("drain_stream", 79'(q.size()), 79'(0), ALL);

      // Stall: A held in main, B in skid, C refused until main drains.
      out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'h0, 5'd3, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h0020C433, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'h4, 5'd8, 1, 0, 0, 0, 0, 0), ALL);
      chk("skid_full_in_ready", 79'(in_ready), 79'(0), ALL);
      chk("stall_out_valid", 79'(out_valid), 79'(1), ALL);
      instr    = 32'h0020E4B3;
      cur.v    = mk(32'd1, 32'd2, 4'h3, 5'd9, 1, 0, 0, 0, 0, 0);
      cur.m    = ALL;
      in_valid = 1'b1;
      tick();
      chk("c_refused_1", 79'(acc), 79'(0), ALL);
      tick();
      chk("c_refused_2", 79'(acc), 79'(0), ALL);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) tick();
      in_valid = 1'b0;
      chk("c_accepted", 79'(acc), 79'(1), ALL);
      tick();
      tick();
      chk("drain_stall", 79'(q.size()), 79'(0), ALL);

      // Flush with both entries full, a word offered in the flush cycle.
      out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd3, 32'd4, mk(32'd3, 32'd4, 4'h0, 5'd3, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h0020C433, 32'h0, 32'd3, 32'd4, mk(32'd3, 32'd4, 4'h4, 5'd8, 1, 0, 0, 0, 0, 0), ALL);
      instr = 32'h0020E4B3; in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 79'(out_valid), 79'(0), ALL);
      chk("flush_in_ready", 79'(in_ready), 79'(1), ALL);
      out_ready = 1'b1;
      send(32'h40435293, 32'h0, 32'h80000000, 32'h0,
           mk(32'h80000000, 32'h4, 4'hF, 5'd5, 1, 0, 0, 0, 0, 0), ALL);
      chk("post_flush_latency", 79'(out_valid), 79'(1), ALL);
      tick();
      chk("drain_flush", 79'(q.size()), 79'(0), ALL);

      // Flush on an empty stage drops the word offered alongside it.
      instr = 32'h002081B3; in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_drop_1", 79'(out_valid), 79'(0), ALL);
      tick();
      chk("flush_drop_2", 79'(out_valid), 79'(0), ALL);

      // Reset in the middle of a full stall.
      out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd6, 32'd7, mk(32'd6, 32'd7, 4'h0, 5'd3, 1, 0, 0, 0, 0, 0), ALL);
      send(32'h0020C433, 32'h0, 32'd6, 32'd7, mk(32'd6, 32'd7, 4'h4, 5'd8, 1, 0, 0, 0, 0, 0), ALL);
      rst = 1'b1; flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      chk("midrst_out_valid", 79'(out_valid), 79'(0), ALL);
      chk("midrst_in_ready", 79'(in_ready), 79'(1), ALL);
      chk("midrst_data", obs, 79'(0), ALL);
      out_ready = 1'b1;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
